// File: rtl/gemm_sequencer.sv
// Signed GEMM sequencer: one A*B read per cycle, then drain and write per C element. Done follows start by M*N*(K+2)+1 cycles.
// Stall freezes issue, drain and write in place. A product already in flight is still accumulated.
module gemm_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS_A     = 4,
  parameter int COLS_A     = 4,
  parameter int COLS_B     = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode_sat,
  input  logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic                  en_ReadMat_A,
  output logic                  en_ReadMat_B,
  output logic [ADDR_WIDTH-1:0] rowAddr_A,
  output logic [ADDR_WIDTH-1:0] colAddr_A,
  output logic [ADDR_WIDTH-1:0] rowAddr_B,
  output logic [ADDR_WIDTH-1:0] colAddr_B,
  input  logic [DATA_WIDTH-1:0] readData_A,
  input  logic [DATA_WIDTH-1:0] readData_B,
  output logic                  en_WriteMat_C,
  output logic [ADDR_WIDTH-1:0] rowAddr_C,
  output logic [ADDR_WIDTH-1:0] colAddr_C,
  output logic [DATA_WIDTH-1:0] writeData_C
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int ACC_W  = 2 * DATA_WIDTH + $clog2(COLS_A) + 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_I = ADDR_WIDTH'(ROWS_A - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_J = ADDR_WIDTH'(COLS_B - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(COLS_A - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] i;
    logic [ADDR_WIDTH-1:0] j;
    logic [ADDR_WIDTH-1:0] k;
  } idx_t;

  state_t                   state_q, state_d;
  idx_t                     idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     vld_q, vld_d;
  logic                     mode_q, mode_d;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic [DATA_WIDTH-1:0]    conv_dat;

  assign prod     = $signed(readData_A) * $signed(readData_B);
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  always_comb begin
    conv_dat = acc_q[DATA_WIDTH-1:0];
    if (mode_q) begin
      if (acc_q > SAT_MAX) begin
        conv_dat = SAT_MAX[DATA_WIDTH-1:0];
      end else if (acc_q < SAT_MIN) begin
        conv_dat = SAT_MIN[DATA_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    vld_d         = 1'b0;
    mode_d        = mode_q;
    busy          = 1'b0;
    done          = 1'b0;
    en_ReadMat_A  = 1'b0;
    en_ReadMat_B  = 1'b0;
    rowAddr_A     = '0;
    colAddr_A     = '0;
    rowAddr_B     = '0;
    colAddr_B     = '0;
    en_WriteMat_C = 1'b0;
    rowAddr_C     = '0;
    colAddr_C     = '0;
    writeData_C   = '0;

    // Read data arrives one cycle after its strobe, whatever the state or stall.
    if (vld_q) begin
      acc_d = acc_q + prod_ext;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
          acc_d   = '0;
          mode_d  = mode_sat;
        end
      end

      S_RUN: begin
        busy      = 1'b1;
        rowAddr_A = idx_q.i;
        colAddr_A = idx_q.k;
        rowAddr_B = idx_q.k;
        colAddr_B = idx_q.j;
        if (!stall) begin
          en_ReadMat_A = 1'b1;
          en_ReadMat_B = 1'b1;
          vld_d        = 1'b1;
          if (idx_q.k == LAST_K) begin
            idx_d.k = '0;
            state_d = S_DRAIN;
          end else begin
            idx_d.k = idx_q.k + 1'b1;
          end
        end
      end

      S_DRAIN: begin
        busy = 1'b1;
        if (!stall) begin
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        busy        = 1'b1;
        rowAddr_C   = idx_q.i;
        colAddr_C   = idx_q.j;
        writeData_C = conv_dat;
        if (!stall) begin
          // A write coinciding with reset is suppressed so it never lands.
          en_WriteMat_C = ~reset;
          acc_d         = '0;
          if (idx_q.j == LAST_J) begin
            idx_d.j = '0;
            if (idx_q.i == LAST_I) begin
              idx_d.i = '0;
              state_d = S_DONE;
            end else begin
              idx_d.i = idx_q.i + 1'b1;
              state_d = S_RUN;
            end
          end else begin
            idx_d.j = idx_q.j + 1'b1;
            state_d = S_RUN;
          end
        end
      end

      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      vld_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      vld_q   <= vld_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: doc/gemm_sequencer.md
GEMM_SEQUENCER -- requirements
Module: gemm_sequencer

Interface
REQ-001 Parameters SHALL be declared as follows, one per line (name, default, meaning):
  DATA_WIDTH, 8, signed element width of A, B and C.
  ROWS_A, 4, M, rows of A and of C.
  COLS_A, 4, K, columns of A and rows of B.
  COLS_B, 4, N, columns of B and of C.
  ADDR_WIDTH, 4, row/column address width.
REQ-002 Parameter legality SHALL be 1 <= M,K,N <= 2^ADDR_WIDTH.
REQ-003 Ports SHALL be as follows, one per line (name, direction, width, meaning):
  clk  in  1  sole clock, rising edge.
  reset  in  1  one clock; reset is synchronous and active-high.
  start  in  1  begin a multiply; sampled only in IDLE.
  mode_sat  in  1  1 = saturate C, 0 = wrap C; latched when start is accepted.
  stall  in  1  freeze sequencing while high.
  busy  out  1  operation in progress.
  done  out  1  one-cycle completion pulse.
  en_ReadMat_A / en_ReadMat_B  out  1  read strobes.
  rowAddr_A, colAddr_A, rowAddr_B, colAddr_B  out  ADDR_WIDTH  read addresses.
  readData_A / readData_B  in  DATA_WIDTH  returned data, valid 1 cycle after the strobe.
  en_WriteMat_C  out  1  write strobe for C.
  rowAddr_C, colAddr_C  out  ADDR_WIDTH  write address.
  writeData_C  out  DATA_WIDTH  write data.

Function
REQ-004 The block SHALL compute C[i][j] = sum over k of A[i][k]*B[k][j] using signed two's-complement operands.
REQ-005 The internal accumulator SHALL be ACC = 2*DATA_WIDTH + clog2(K) + 1 bits wide so that no intermediate overflow occurs.
REQ-006 The FSM SHALL have the states IDLE, RUN, DRAIN, WRITE and DONE.
REQ-007 IDLE -> RUN SHALL occur on start=1; start SHALL be ignored in every other state.
REQ-008 RUN (per element i,j, for k = 0..K-1): en_ReadMat_A = en_ReadMat_B = 1, rowAddr_A = i, colAddr_A = k, rowAddr_B = k, colAddr_B = j.
REQ-009 In RUN, after k = K-1 is issued, the FSM SHALL go to DRAIN.
REQ-010 A one-bit valid pipe SHALL mark every issued read; the cycle after each issue, ACC SHALL be updated to ACC + readData_A*readData_B.
REQ-011 DRAIN SHALL last one cycle, accumulate the final product and then go to WRITE.
REQ-012 WRITE SHALL assert en_WriteMat_C = 1 for exactly one cycle with rowAddr_C = i, colAddr_C = j and writeData_C = the converted ACC, then clear ACC to 0.
REQ-013 Iteration order SHALL be j fastest, then i.
REQ-014 After WRITE, the FSM SHALL go to RUN for the next element, or to DONE after element (M-1, N-1).
REQ-015 DONE SHALL assert done = 1 for one cycle and then go to IDLE.
REQ-016 Conversion with mode_sat = 1 SHALL clamp ACC to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-017 Conversion with mode_sat = 0 SHALL take ACC[DATA_WIDTH-1:0].
REQ-018 busy SHALL be 1 in RUN, DRAIN, WRITE and DONE, and 0 in IDLE.
REQ-019 Latency: with stall held low, the first read strobe SHALL occur in the cycle after start is accepted and done SHALL occur M*N*(K+2)+1 cycles after the accepting edge.
REQ-020 Stall behaviour SHALL be:
  - stall=1 in RUN: no read issued, k held, an in-flight product still accumulated.
  - stall=1 in DRAIN/WRITE: state held, en_WriteMat_C = 0.
  - stall is ignored in IDLE and DONE.
  - each stalled cycle delays done by exactly one cycle.
REQ-021 Read/write strobes SHALL be 0 and all addresses SHALL be 0 in IDLE and DONE.
REQ-022 A K=1 instance SHALL work (RUN one cycle per element); an M=N=1 instance SHALL produce exactly one write.

Reset
REQ-023 When reset=1 at a rising edge, the block SHALL enter IDLE with all outputs, counters, ACC, valid pipe and the mode latch cleared to 0 on the following cycle, regardless of state.
REQ-024 A write in progress SHALL NOT complete after reset is asserted.
REQ-025 After reset, the next accepted start SHALL begin a fresh computation from element (0,0).

Verification
REQ-026 Identity: M=K=N=4, A = identity, B[r][c] = 4r+c, mode_sat=0 -> 16 writes with C[r][c] = 4r+c in order (0,0),(0,1)..(3,3); done 97 cycles after start.
REQ-027 Saturation: A = B = all 0x7F -> mode_sat=1 gives every C = 0x7F; mode_sat=0 gives every C = 0x04.
REQ-028 Negative saturation: A = all 0x80, B = all 0x7F -> mode_sat=1 gives C = 0x80; mode_sat=0 gives C = 0x00.
REQ-029 Stall: same stimulus as REQ-026 with stall high 3 cycles in RUN and 2 cycles in WRITE -> identical C values; done delayed by exactly 5 cycles; no extra or missing strobes.
REQ-030 Reset and start: reset asserted 40 cycles into a run -> busy, strobes and addresses are 0 next cycle and no further writes occur; a start pulse during busy or DONE is ignored; a start in the cycle after done is accepted.
REQ-031 Degenerate size: M=N=K=1 instance with A=0x03, B=0xFB -> one write of 0xF1 at address (0,0); done 4 cycles after start.
